// File: rtl/i2c_byte_engine_if.sv
// Command/response bundle between the Wishbone register block (master) and the
// I2C byte engine (slave).
interface i2c_byte_engine_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_tx_data;
    logic       cmd_nack;
    logic       done;
    logic [7:0] rx_data;
    logic       rx_ack;
    logic       bus_active;
    logic       arb_lost;

    modport master (
        output cmd_valid, cmd_op, cmd_tx_data, cmd_nack,
        input  cmd_ready, done, rx_data, rx_ack, bus_active, arb_lost
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_tx_data, cmd_nack,
        output cmd_ready, done, rx_data, rx_ack, bus_active, arb_lost
    );
endinterface

// File: rtl/i2c_byte_engine.sv
// I2C master byte engine: START / WRITE / READ / STOP sequenced at quarter-bit
// granularity. Define I2C_ARB_DETECT_EN to enable arbitration-loss abort.
module i2c_byte_engine #(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_byte_engine_if.slave   host,
    input  logic               sda_i,
    output logic               sda_o,
    output logic               sda_o_en,
    output logic               scl_o
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_WBIT, S_RBIT, S_STOP} state_t;

    localparam logic [7:0] QLAST = 8'(CLK_DIV - 1);

    state_t      state, state_nxt;
    logic [7:0]  qcnt;
    logic [1:0]  q;
    logic [3:0]  bitcnt;
    logic [7:0]  tx_byte;
    logic [7:0]  rx_shift;
    logic        nack_r;
    logic        ack_smp;
    logic        scl_last;
    logic        done_r;
    logic [7:0]  rx_data_r;
    logic        rx_ack_r;
    logic        bus_active_r;
    logic        accept, q_end, sample_en, finish, tx_bit, arb_hit;

    assign accept    = host.cmd_valid && host.cmd_ready;
    assign q_end     = (qcnt == QLAST);
    assign sample_en = q_end && (q == 2'd1);
    assign tx_bit    = tx_byte[3'd7 - bitcnt[2:0]];
    assign finish    = q_end && (q == 2'd3) &&
                       ((state == S_START) || (state == S_STOP) ||
                        (((state == S_WBIT) || (state == S_RBIT)) && (bitcnt == 4'd8)));

`ifdef I2C_ARB_DETECT_EN
    logic arb_lost_r;
    // Lost when we released SDA but someone else holds it low at the sample point.
    assign arb_hit = sample_en && !sda_i &&
                     ((state == S_START) ||
                      ((state == S_WBIT) && (bitcnt != 4'd8) && tx_bit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arb_lost_r <= 1'b0;
        else        arb_lost_r <= arb_hit;
    end
    assign host.arb_lost = arb_lost_r;
`else
    assign arb_hit       = 1'b0;
    assign host.arb_lost = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (host.cmd_op)
                        2'b00:   state_nxt = S_START;
                        2'b01:   state_nxt = S_WBIT;
                        2'b10:   state_nxt = S_RBIT;
                        default: state_nxt = S_STOP;
                    endcase
                end
            end
            default: if (arb_hit || finish) state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        scl_o          = scl_last;
        sda_o_en       = 1'b0;
        host.cmd_ready = (state == S_IDLE) && !done_r;
        case (state)
            S_START: begin
                scl_o    = (q == 2'd0) ? scl_last : (q != 2'd3);
                sda_o_en = q[1];
            end
            S_WBIT: begin
                scl_o    = (q == 2'd1) || (q == 2'd2);
                sda_o_en = (bitcnt != 4'd8) && !tx_bit;
            end
            S_RBIT: begin
                scl_o    = (q == 2'd1) || (q == 2'd2);
                sda_o_en = (bitcnt == 4'd8) && !nack_r;
            end
            S_STOP: begin
                scl_o    = (q != 2'd0);
                sda_o_en = !q[1];
            end
            default: ;
        endcase
        sda_o = !sda_o_en;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt         <= 8'd0;
            q            <= 2'd0;
            bitcnt       <= 4'd0;
            ack_smp      <= 1'b1;
            scl_last     <= 1'b1;
            done_r       <= 1'b0;
            rx_data_r    <= 8'h00;
            rx_ack_r     <= 1'b1;
            bus_active_r <= 1'b0;
        end else begin
            done_r   <= finish || arb_hit;
            scl_last <= arb_hit ? 1'b1 : scl_o;
            if (accept) begin
                qcnt   <= 8'd0;
                q      <= 2'd0;
                bitcnt <= 4'd0;
            end else if (state != S_IDLE) begin
                if (q_end) begin
                    qcnt <= 8'd0;
                    q    <= q + 2'd1;
                    if (q == 2'd3) bitcnt <= bitcnt + 4'd1;
                end else begin
                    qcnt <= qcnt + 8'd1;
                end
            end
            if (sample_en && (state == S_WBIT) && (bitcnt == 4'd8)) ack_smp <= sda_i;
            // Results are published only when the byte completes, never on abort.
            if (finish && (state == S_WBIT)) rx_ack_r  <= ack_smp;
            if (finish && (state == S_RBIT)) rx_data_r <= rx_shift;
            if (finish && (state == S_START)) bus_active_r <= 1'b1;
            if ((finish && (state == S_STOP)) || arb_hit) bus_active_r <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tx_byte <= host.cmd_tx_data;
            nack_r  <= host.cmd_nack;
        end
        if (sample_en && (state == S_RBIT) && (bitcnt != 4'd8))
            rx_shift <= {rx_shift[6:0], sda_i};
    end

    assign host.done       = done_r;
    assign host.rx_data    = rx_data_r;
    assign host.rx_ack     = rx_ack_r;
    assign host.bus_active = bus_active_r;
endmodule

// File: tb/tb_i2c_byte_engine.sv
// Bench for i2c_byte_engine: directed commands, a cycle-level bus model that
// predicts SCL/SDA and status outputs, and literal checks of key results.
module tb_i2c_byte_engine;
    localparam int N = 4;
    localparam logic [1:0] OP_START = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10, OP_STOP = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sda_o, sda_o_en, scl_o;
    logic sda_line, slave_now;

    i2c_byte_engine_if ifc ();

    i2c_byte_engine #(.CLK_DIV(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .host     (ifc),
        .sda_i    (sda_line),
        .sda_o    (sda_o),
        .sda_o_en (sda_o_en),
        .scl_o    (scl_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Slave behaviour and expected results
    logic [7:0] s_byte  = 8'h00;
    logic       s_ack   = 1'b1;
    logic       s_pull7 = 1'b0;

    // Model state
    logic       m_busy = 1'b0, m_done = 1'b0, m_arb = 1'b0;
    logic [1:0] m_op = 2'b00;
    int         m_k = 0;
    logic [7:0] m_tx = 8'h00;
    logic       m_nack = 1'b0;
    logic       m_scl_idle = 1'b1;
    logic [7:0] m_rx_data = 8'h00;
    logic       m_rx_ack = 1'b1;
    logic       m_bus = 1'b0;
    logic [7:0] rec_bits = 8'h00;
    logic [8:0] en_rec = 9'h000;
    logic       cmp_on = 1'b0;
    logic       e_scl, e_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int op_len(input logic [1:0] op);
        return (op == OP_START || op == OP_STOP) ? 4 * N : 36 * N;
    endfunction

    // Bit the slave leaves on the wire for cycle k of the current command.
    function automatic logic slave_bit(input logic busy, input logic [1:0] op, input int k,
                                       input logic [7:0] sb, input logic sa, input logic p7);
        int slot;
        slot = (k - 1) / (4 * N);
        if (!busy) return 1'b1;
        if (op == OP_RD && slot < 8) return sb[7 - slot];
        if (op == OP_WR && slot == 8) return sa;
        if (op == OP_WR && slot == 0 && p7) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void exp_pins(input logic busy, input logic [1:0] op, input int k,
                                     input logic scl_idle, input logic [7:0] tx, input logic nk,
                                     output logic scl, output logic en);
        int slot, qq;
        scl = scl_idle;
        en  = 1'b0;
        if (busy) begin
            slot = (k - 1) / (4 * N);
            qq   = ((k - 1) / N) % 4;
            case (op)
                OP_START: begin scl = (qq == 0) ? scl_idle : (qq != 3); en = (qq >= 2); end
                OP_STOP:  begin scl = (qq != 0); en = (qq <= 1); end
                OP_WR:    begin scl = (qq == 1 || qq == 2); en = (slot < 8) ? !tx[7 - slot] : 1'b0; end
                default:  begin scl = (qq == 1 || qq == 2); en = (slot == 8) ? !nk : 1'b0; end
            endcase
        end
    endfunction

    assign slave_now = slave_bit(m_busy, m_op, m_k, s_byte, s_ack, s_pull7);
    assign sda_line  = slave_now & ~sda_o_en;

    always @(posedge clk or negedge rst_n) begin
        logic acc, smp, lost;
        int   slot, qq;
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_arb = 1'b0; m_k = 0;
            m_scl_idle = 1'b1; m_rx_data = 8'h00; m_rx_ack = 1'b1; m_bus = 1'b0;
        end else begin
            acc    = !m_busy && !m_done && ifc.cmd_valid;
            m_done = 1'b0;
            m_arb  = 1'b0;
            if (m_busy) begin
                slot = (m_k - 1) / (4 * N);
                qq   = ((m_k - 1) / N) % 4;
                smp  = (qq == 1) && ((m_k - 1) % N == N - 1);
                if (m_op == OP_WR || m_op == OP_RD) begin
                    if (smp && slot < 8) rec_bits[7 - slot] = sda_line;
                    if (sda_o_en) en_rec[slot] = 1'b1;
                end
                lost = 1'b0;
`ifdef I2C_ARB_DETECT_EN
                lost = smp && !slave_bit(m_busy, m_op, m_k, s_byte, s_ack, s_pull7) &&
                       ((m_op == OP_START) || (m_op == OP_WR && slot < 8 && m_tx[7 - slot]));
`endif
                if (lost) begin
                    m_busy = 1'b0; m_done = 1'b0; m_done = 1'b1; m_arb = 1'b1;
                    m_bus = 1'b0; m_scl_idle = 1'b1;
                end else if (m_k == op_len(m_op)) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    case (m_op)
                        OP_START: begin m_bus = 1'b1; m_scl_idle = 1'b0; end
                        OP_STOP:  begin m_bus = 1'b0; m_scl_idle = 1'b1; end
                        OP_WR:    begin m_rx_ack = s_ack; m_scl_idle = 1'b0; end
                        default:  begin m_rx_data = s_byte; m_scl_idle = 1'b0; end
                    endcase
                end else begin
                    m_k++;
                end
            end
            if (acc) begin
                m_busy = 1'b1; m_k = 1; m_op = ifc.cmd_op;
                m_tx = ifc.cmd_tx_data; m_nack = ifc.cmd_nack;
                rec_bits = 8'h00; en_rec = 9'h000;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_on) begin
            exp_pins(m_busy, m_op, m_k, m_scl_idle, m_tx, m_nack, e_scl, e_en);
            chk("scl_o", scl_o, e_scl);
            chk("sda_o_en", sda_o_en, e_en);
            chk("sda_o", sda_o, !e_en);
            chk("done", ifc.done, m_done);
            chk("arb_lost", ifc.arb_lost, m_arb);
            chk("cmd_ready", ifc.cmd_ready, !m_busy && !m_done);
            chk("bus_active", ifc.bus_active, m_bus);
            chk("rx_data", ifc.rx_data, m_rx_data);
            chk("rx_ack", ifc.rx_ack, m_rx_ack);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] tx, input logic nk);
        logic got;
        got = 1'b0;
        @(negedge clk);
        ifc.cmd_valid = 1'b1; ifc.cmd_op = op; ifc.cmd_tx_data = tx; ifc.cmd_nack = nk;
        for (int i = 0; i < 100; i++) begin
            if (ifc.cmd_ready) begin got = 1'b1; break; end
            @(negedge clk);
        end
        if (!got) chk("ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        logic seen;
        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (ifc.done) begin seen = 1'b1; break; end
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat;
        ifc.cmd_valid = 1'b0; ifc.cmd_op = 2'b00; ifc.cmd_tx_data = 8'h00; ifc.cmd_nack = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", ifc.cmd_ready, 1);
        chk("rst_done", ifc.done, 0);
        chk("rst_rx_data", ifc.rx_data, 8'h00);
        chk("rst_rx_ack", ifc.rx_ack, 1);
        chk("rst_bus_active", ifc.bus_active, 0);
        chk("rst_scl", scl_o, 1);
        chk("rst_sda_o_en", sda_o_en, 0);
        chk("rst_sda_o", sda_o, 1);
        #2 rst_n = 1'b1;
        cmp_on = 1'b1;

        issue(OP_START, 8'h00, 1'b0); wait_done(lat);
        chk("start_latency", lat, 16);
        chk("start_bus_active", ifc.bus_active, 1);
        chk("start_scl", scl_o, 0);

        s_ack = 1'b0;
        issue(OP_WR, 8'hA5, 1'b0); wait_done(lat);
        chk("wr_a5_latency", lat, 144);
        chk("wr_a5_bits", rec_bits, 8'hA5);
        chk("wr_a5_rx_ack", ifc.rx_ack, 0);

        s_ack = 1'b1;
        issue(OP_WR, 8'h3C, 1'b0); wait_done(lat);
        chk("wr_3c_rx_ack", ifc.rx_ack, 1);
        chk("wr_3c_drive_slots", en_rec, 9'h0C3);

        s_byte = 8'h96;
        issue(OP_RD, 8'h00, 1'b1); wait_done(lat);
        chk("rd_latency", lat, 144);
        chk("rd_rx_data", ifc.rx_data, 8'h96);
        chk("rd_drive_slots", en_rec, 9'h000);

        issue(OP_STOP, 8'h00, 1'b0); wait_done(lat);
        chk("stop_latency", lat, 16);
        chk("stop_bus_active", ifc.bus_active, 0);
        repeat (5) @(negedge clk);
        chk("stop_scl_idle", scl_o, 1);

        issue(OP_START, 8'h00, 1'b0); wait_done(lat);
        s_ack = 1'b0;
        issue(OP_WR, 8'h5A, 1'b0); wait_done(lat);
        chk("wr_5a_rx_ack", ifc.rx_ack, 0);

        // Reset in the middle of bit 3 of a WRITE
        issue(OP_WR, 8'h81, 1'b0);
        repeat (17 * N) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_scl", scl_o, 1);
        chk("midrst_sda_o_en", sda_o_en, 0);
        chk("midrst_cmd_ready", ifc.cmd_ready, 1);
        chk("midrst_rx_ack", ifc.rx_ack, 1);
        chk("midrst_done", ifc.done, 0);
        chk("midrst_bus_active", ifc.bus_active, 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("midrst_no_done", ifc.done, 0);

        issue(OP_START, 8'h00, 1'b0); wait_done(lat);
        chk("restart_latency", lat, 16);
        chk("restart_bus_active", ifc.bus_active, 1);

        // Another master holds SDA low through bit 7 while we send 0xFF
        s_ack = 1'b0; s_pull7 = 1'b1;
        issue(OP_WR, 8'hFF, 1'b0); wait_done(lat);
`ifdef I2C_ARB_DETECT_EN
        chk("arb_latency", lat, 2 * N);
        chk("arb_lost_pulse", ifc.arb_lost, 1);
        chk("arb_bus_active", ifc.bus_active, 0);
        chk("arb_scl", scl_o, 1);
        chk("arb_sda_o_en", sda_o_en, 0);
        chk("arb_rx_ack_kept", ifc.rx_ack, 1);
`else
        chk("noarb_latency", lat, 144);
        chk("noarb_arb_lost", ifc.arb_lost, 0);
        chk("noarb_rx_ack", ifc.rx_ack, 0);
        chk("noarb_bus_active", ifc.bus_active, 1);
`endif
        s_pull7 = 1'b0;
        issue(OP_STOP, 8'h00, 1'b0); wait_done(lat);
        chk("final_stop_bus_active", ifc.bus_active, 0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
